// File: rtl/spi_poll_sched.sv
`default_nettype none
// ============================================================================
//  Module   : spi_poll_sched
//  Purpose  : Sequencer and round-robin arbiter for a shared 40-bit SPI frame
//             engine. Generates the engine clock-enable tick and start pulse,
//             routes the engine slave-select to the granted device, returns
//             each completed frame tagged with its device index, and aborts
//             any frame that exceeds a tick-based timeout.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             req[NUM_DEV]        - poll request pulses (one per device)
//             tick, eng_start     - engine clock-enable and frame start
//             eng_ss, eng_valid,
//             eng_data[40]        - engine select, frame-done, frame data
//             ss_n[NUM_DEV]       - per-device select, active low
//             dev_sel[3], busy    - granted device, sequencer active
//             frame_valid,
//             frame_dev[3],
//             frame_data[40]      - accepted frame and its device index
//             timeout_err         - single-cycle abort pulse
//  Config   : SPI_SCHED_AUTOPOLL_EN - when defined, an empty pending set is
//             refilled with all devices, giving continuous polling.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_poll_sched #(
    parameter int NUM_DEV       = 2,
    parameter int CLK_DIV       = 50,
    parameter int GAP_TICKS     = 40,
    parameter int TIMEOUT_TICKS = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DEV-1:0] req,
    output logic               tick,
    output logic               eng_start,
    input  logic               eng_ss,
    input  logic               eng_valid,
    input  logic [39:0]        eng_data,
    output logic [NUM_DEV-1:0] ss_n,
    output logic [2:0]         dev_sel,
    output logic               busy,
    output logic               frame_valid,
    output logic [2:0]         frame_dev,
    output logic [39:0]        frame_data,
    output logic               timeout_err
);

    localparam int c_DIV_W = $clog2(CLK_DIV);
    localparam int c_GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [c_DIV_W-1:0]   r_div_q, w_div_d;
    logic [NUM_DEV-1:0]   r_pend_q, w_pend_d;
    logic [2:0]           r_last_q, w_last_d;
    logic [2:0]           r_dev_sel_q, w_dev_sel_d;
    logic [9:0]           r_tmo_q, w_tmo_d;
    logic [c_GAP_W-1:0]   r_gap_q, w_gap_d;
    logic                 r_rereq_q, w_rereq_d;
    logic [2:0]           r_frame_dev_q;
    logic [39:0]          r_frame_data_q;

    logic                 w_tick;
    logic [NUM_DEV-1:0]   w_req_vis;
    logic [NUM_DEV-1:0]   w_sel_oh;
    logic [NUM_DEV-1:0]   w_clr;
    logic [NUM_DEV-1:0]   w_pend_base;
    logic                 w_found;
    logic [2:0]           w_win;
    logic                 w_cap;
    logic                 w_refill;

    // Free-running tick divider
    assign w_tick  = (r_div_q == c_DIV_W'(CLK_DIV - 1));
    assign w_div_d = w_tick ? '0 : r_div_q + c_DIV_W'(1);

    // Requests arriving this cycle are visible to the arbiter immediately so
    // an idle sequencer grants on the same edge that latches the request.
    assign w_req_vis = r_pend_q | req;

    always_comb begin
        w_sel_oh = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            w_sel_oh[i] = (r_dev_sel_q == 3'(i));
        end
    end

    // Round-robin search starting just after the last granted device
    always_comb begin : p_arb
        logic [3:0] idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = '0;
        for (int k = 1; k <= NUM_DEV; k++) begin
            idx = {1'b0, r_last_q} + 4'(k);
            if (idx >= 4'(NUM_DEV)) begin
                idx = idx - 4'(NUM_DEV);
            end
            for (int i = 0; i < NUM_DEV; i++) begin
                if (!w_found && (idx == 4'(i)) && w_req_vis[i]) begin
                    w_found = 1'b1;
                    w_win   = 3'(i);
                end
            end
        end
    end

    // Sequencer next-state and pulse outputs
    always_comb begin
        w_state_d   = r_state_q;
        w_last_d    = r_last_q;
        w_dev_sel_d = r_dev_sel_q;
        w_tmo_d     = r_tmo_q;
        w_gap_d     = r_gap_q;
        w_clr       = '0;
        w_cap       = 1'b0;
        w_refill    = 1'b0;
        eng_start   = 1'b0;
        timeout_err = 1'b0;
        frame_valid = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (w_found) begin
                    w_dev_sel_d = w_win;
                    w_last_d    = w_win;
                    w_state_d   = S_START;
                end
`ifdef SPI_SCHED_AUTOPOLL_EN
                // Also primes the pending set after reset, when no GAP exit
                // has happened yet.
                w_refill = 1'b1;
`endif
            end
            S_START: begin
                if (w_tick) begin
                    eng_start = 1'b1;
                    w_tmo_d   = '0;
                    w_state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_valid) begin
                    w_cap     = 1'b1;
                    w_state_d = S_DONE;
                end else if (w_tick) begin
                    if (r_tmo_q == 10'(TIMEOUT_TICKS - 1)) begin
                        timeout_err = 1'b1;
                        w_clr       = w_sel_oh;
                        w_gap_d     = '0;
                        w_state_d   = S_GAP;
                    end else begin
                        w_tmo_d = r_tmo_q + 10'd1;
                    end
                end
            end
            S_DONE: begin
                frame_valid = 1'b1;
                w_clr       = w_sel_oh;
                w_gap_d     = '0;
                w_state_d   = S_GAP;
            end
            S_GAP: begin
                if (w_tick) begin
                    if (r_gap_q == c_GAP_W'(GAP_TICKS - 1)) begin
                        w_state_d = S_IDLE;
`ifdef SPI_SCHED_AUTOPOLL_EN
                        w_refill  = 1'b1;
`endif
                    end else begin
                        w_gap_d = r_gap_q + c_GAP_W'(1);
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // A request for the active device would otherwise be swallowed by the
    // clear at frame end; remember it and re-set the bit as it clears.
    always_comb begin
        w_rereq_d = 1'b0;
        if ((r_state_q == S_START || r_state_q == S_WAIT) && (w_clr == '0)) begin
            w_rereq_d = r_rereq_q | (|(req & w_sel_oh));
        end
    end

    // Set wins over clear on the same bit
    assign w_pend_base = (r_pend_q & ~w_clr) | req | (w_clr & {NUM_DEV{r_rereq_q}});
    assign w_pend_d    = (w_refill && (w_pend_base == '0)) ? '1 : w_pend_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= S_IDLE;
            r_div_q        <= '0;
            r_pend_q       <= '0;
            r_last_q       <= 3'(NUM_DEV - 1);
            r_dev_sel_q    <= '0;
            r_tmo_q        <= '0;
            r_gap_q        <= '0;
            r_rereq_q      <= 1'b0;
            r_frame_dev_q  <= '0;
            r_frame_data_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_div_q     <= w_div_d;
            r_pend_q    <= w_pend_d;
            r_last_q    <= w_last_d;
            r_dev_sel_q <= w_dev_sel_d;
            r_tmo_q     <= w_tmo_d;
            r_gap_q     <= w_gap_d;
            r_rereq_q   <= w_rereq_d;
            if (w_cap) begin
                r_frame_dev_q  <= r_dev_sel_q;
                r_frame_data_q <= eng_data;
            end
        end
    end

    // Engine select reaches only the granted device while a frame is open
    always_comb begin
        ss_n = '1;
        if (r_state_q == S_START || r_state_q == S_WAIT) begin
            ss_n = ~(w_sel_oh & {NUM_DEV{~eng_ss}});
        end
    end

    assign tick       = w_tick;
    assign busy       = (r_state_q != S_IDLE);
    assign dev_sel    = r_dev_sel_q;
    assign frame_dev  = r_frame_dev_q;
    assign frame_data = r_frame_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_poll_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_poll_sched
//  Purpose  : Directed self-checking bench for spi_poll_sched with a small
//             behavioural model of the SPI frame engine.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_poll_sched;

`ifdef SPI_SCHED_AUTOPOLL_EN
    localparam int N = 3;
`else
    localparam int N = 2;
`endif
    localparam int CLK_DIV   = 4;
    localparam int GAP_TICKS = 3;
    localparam int TMO_TICKS = 8;
    localparam logic [N-1:0] c_ALL1 = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic          tick, eng_start, busy, frame_valid, timeout_err;
    logic          eng_ss = 1'b1;
    logic          m_valid = 1'b0;
    logic          inj_valid = 1'b0;
    logic          eng_valid;
    logic [39:0]   eng_data;
    logic [39:0]   resp_data = 40'hA5_0102_03C3;
    logic          eng_respond = 1'b1;
    logic [N-1:0]  ss_n;
    logic [2:0]    dev_sel, frame_dev;
    logic [39:0]   frame_data;

    int n_checks = 0;
    int n_fail   = 0;
    int fv_cnt   = 0;
    int to_cnt   = 0;
    bit e_act    = 1'b0;
    int e_ticks  = 0;

    assign eng_valid = m_valid | inj_valid;
    assign eng_data  = resp_data;

    spi_poll_sched #(
        .NUM_DEV      (N),
        .CLK_DIV      (CLK_DIV),
        .GAP_TICKS    (GAP_TICKS),
        .TIMEOUT_TICKS(TMO_TICKS)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .tick       (tick),
        .eng_start  (eng_start),
        .eng_ss     (eng_ss),
        .eng_valid  (eng_valid),
        .eng_data   (eng_data),
        .ss_n       (ss_n),
        .dev_sel    (dev_sel),
        .busy       (busy),
        .frame_valid(frame_valid),
        .frame_dev  (frame_dev),
        .frame_data (frame_data),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Engine model: select low from start, frame-done on its 3rd tick
    always @(negedge clk) begin
        if (rst) begin
            eng_ss  = 1'b1;
            m_valid = 1'b0;
            e_act   = 1'b0;
            e_ticks = 0;
        end else if (m_valid) begin
            m_valid = 1'b0;
            eng_ss  = 1'b1;
            e_act   = 1'b0;
        end else if (e_act) begin
            if (timeout_err) begin
                e_act  = 1'b0;
                eng_ss = 1'b1;
            end else if (tick) begin
                e_ticks++;
                if (e_ticks == 3 && eng_respond) m_valid = 1'b1;
            end
        end else if (eng_start) begin
            e_act   = 1'b1;
            eng_ss  = 1'b0;
            e_ticks = 0;
        end
    end

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (timeout_err) to_cnt++;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_req(input logic [N-1:0] v);
        req = v;
        step(1);
        req = '0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!eng_start && n < 50) begin
            step(1);
            n++;
        end
        check_val("eng_start_seen", 64'(eng_start), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            step(1);
            n++;
        end
        check_val("idle_reached", 64'(busy), 64'd0);
    endtask

    task automatic wait_frame(input string tag, input logic [2:0] exp_dev, input logic [39:0] exp_data);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!frame_valid && n < 400);
        check_val({tag, "_seen"}, 64'(frame_valid), 64'd1);
        check_val({tag, "_dev"}, 64'(frame_dev), 64'(exp_dev));
        check_val({tag, "_data"}, 64'(frame_data), 64'(exp_data));
    endtask

    // Called with rst just released ahead of the next edge: tick is high in
    // the CLK_DIV-th cycle after release, i.e. after CLK_DIV-1 edges.
    task automatic first_tick(input string tag);
        int n = 0;
        while (!tick && n < 20) begin
            step(1);
            n++;
        end
        check_val(tag, 64'(n), 64'(CLK_DIV - 1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        int fv0;
        rst = 1'b1;
        step(3);
        check_val("rst_ss_n", 64'(ss_n), 64'(c_ALL1));
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_tick", 64'(tick), 64'd0);
        check_val("rst_eng_start", 64'(eng_start), 64'd0);
        check_val("rst_frame_valid", 64'(frame_valid), 64'd0);
        check_val("rst_timeout_err", 64'(timeout_err), 64'd0);
        check_val("rst_dev_sel", 64'(dev_sel), 64'd0);
        check_val("rst_frame_dev", 64'(frame_dev), 64'd0);
        check_val("rst_frame_data", 64'(frame_data), 64'd0);
        rst = 1'b0;
        first_tick("first_tick");

`ifdef SPI_SCHED_AUTOPOLL_EN
        for (int i = 0; i < 6; i++) begin
            wait_frame("autopoll", 3'(i % 3), 40'hA5_0102_03C3);
        end
`else
        // Single poll of device 0
        pulse_req(2'b01);
        check_val("grant_busy", 64'(busy), 64'd1);
        check_val("grant_dev_sel", 64'(dev_sel), 64'd0);
        wait_start();
        step(1);
        check_val("ss_wait_dev0", 64'(ss_n), 64'b10);
        wait_frame("single", 3'd0, 40'hA5_0102_03C3);
        step(1);
        check_val("ss_gap", 64'(ss_n), 64'b11);
        check_val("fv_single_pulse", 64'(frame_valid), 64'd0);
        n = 0;
        k = 0;
        while (busy && k < 200) begin
            if (tick) n++;
            step(1);
            k++;
        end
        check_val("gap_ticks", 64'(n), 64'(GAP_TICKS));
        check_val("fv_count_single", 64'(fv_cnt), 64'd1);

        // Simultaneous requests from a fresh pointer
        do_reset();
        pulse_req(2'b11);
        check_val("sim_grant_dev", 64'(dev_sel), 64'd0);
        wait_frame("sim1_a", 3'd0, 40'hA5_0102_03C3);
        resp_data = 40'h11_2233_4455;
        wait_frame("sim1_b", 3'd1, 40'h11_2233_4455);
        wait_idle();
        pulse_req(2'b11);
        wait_frame("sim2_a", 3'd0, 40'h11_2233_4455);
        wait_frame("sim2_b", 3'd1, 40'h11_2233_4455);
        wait_idle();

        // Timeout: engine never completes
        eng_respond = 1'b0;
        resp_data   = 40'hDE_ADBE_EF00;
        fv0 = fv_cnt;
        pulse_req(2'b01);
        wait_start();
        n = 0;
        k = 0;
        do begin
            step(1);
            k++;
            if (tick) n++;
        end while (!timeout_err && k < 100);
        check_val("timeout_seen", 64'(timeout_err), 64'd1);
        check_val("timeout_ticks", 64'(n), 64'(TMO_TICKS));
        check_val("timeout_data_held", 64'(frame_data), 64'h11_2233_4455);
        wait_idle();
        step(3 * CLK_DIV);
        check_val("timeout_pend_cleared", 64'(busy), 64'd0);
        check_val("timeout_no_frame", 64'(fv_cnt), 64'(fv0));
        check_val("timeout_count", 64'(to_cnt), 64'd1);
        eng_respond = 1'b1;

        // Request for the active device during its own frame
        resp_data = 40'h01_2345_6789;
        fv0 = fv_cnt;
        pulse_req(2'b01);
        wait_start();
        step(2);
        pulse_req(2'b01);
        wait_frame("own_1", 3'd0, 40'h01_2345_6789);
        wait_frame("own_2", 3'd0, 40'h01_2345_6789);
        wait_idle();
        check_val("own_frames", 64'(fv_cnt - fv0), 64'd2);

        // eng_valid while idle is ignored
        fv0 = fv_cnt;
        inj_valid = 1'b1;
        step(1);
        inj_valid = 1'b0;
        step(3);
        check_val("idle_valid_ignored", 64'(fv_cnt), 64'(fv0));
        check_val("idle_valid_busy", 64'(busy), 64'd0);

        // Reset in the middle of a frame
        pulse_req(2'b10);
        wait_start();
        step(2);
        check_val("ss_wait_dev1", 64'(ss_n), 64'b01);
        rst = 1'b1;
        step(1);
        check_val("midrst_ss_n", 64'(ss_n), 64'b11);
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_dev_sel", 64'(dev_sel), 64'd0);
        rst = 1'b0;
        first_tick("midrst_first_tick");
        step(4 * CLK_DIV);
        check_val("midrst_pend_cleared", 64'(busy), 64'd0);

        // Without autopoll nothing happens on its own
        n = 0;
        for (int i = 0; i < 10000; i++) begin
            step(1);
            if (busy) n++;
        end
        check_val("no_autopoll_busy", 64'(n), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
